// File: rtl/median_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : median_stream_ctrl
// Purpose  : Frame-level sequencer for the 3x3 median datapath. Accepts a
//            raster pixel stream (valid/ready), drives line-buffer address,
//            write enable and row rotation, gates the window/pipeline enable,
//            and carries an interior-window valid flag down a shift register
//            to the result port with downstream backpressure.
// Ports    : clk, rst (async, active-high)
//            start            - begin a frame (sampled in IDLE only)
//            in_valid/in_ready- upstream pixel handshake
//            out_ready/out_valid - downstream result handshake
//            pipe_en          - enable for window regs and datapath stages
//            lb_wr_en, lb_addr, lb_sel - line-buffer write control
//            col_cnt, row_cnt - current raster position
//            busy, frame_done - status
// Revision : 1.0 - initial release
// ============================================================================
module median_stream_ctrl #(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int ADDR_WIDTH   = 10,
  parameter int PIPE_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  pipe_en,
  output logic                  lb_wr_en,
  output logic [ADDR_WIDTH-1:0] lb_addr,
  output logic [1:0]            lb_sel,
  output logic [ADDR_WIDTH-1:0] col_cnt,
  output logic [15:0]           row_cnt,
  output logic                  busy,
  output logic                  frame_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IMG_WIDTH - 1);
  localparam logic [15:0]           LAST_ROW = 16'(IMG_HEIGHT - 1);

  logic [2:0]              state;
  logic [PIPE_LATENCY-1:0] pipe_v;
  logic [PIPE_LATENCY-1:0] pipe_shift;
  logic [PIPE_LATENCY-1:0] pipe_next;
  logic                    stall;
  logic                    streaming;
  logic                    accept;
  logic                    interior;
  logic                    pipe_in;
  logic                    last_col;
  logic                    last_row;

  assign out_valid = pipe_v[PIPE_LATENCY-1];
  // Only a presented-but-unconsumed result can hold the pipeline.
  assign stall     = out_valid & ~out_ready;
  assign streaming = (state == S_FILL) | (state == S_RUN);
  assign in_ready  = streaming & ~stall;
  assign pipe_en   = (streaming | (state == S_FLUSH)) & ~stall;
  assign accept    = in_valid & in_ready;
  assign lb_wr_en  = accept;
  assign lb_addr   = col_cnt;
  assign busy      = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  assign last_col  = (col_cnt == LAST_COL);
  assign last_row  = (row_cnt == LAST_ROW);
  // A full 3x3 window exists once two prior rows and two prior columns exist.
  assign interior  = (row_cnt >= 16'd2) & (col_cnt >= ADDR_WIDTH'(2));
  assign pipe_in   = accept & interior;

  generate
    if (PIPE_LATENCY == 1) begin : g_pipe_one
      assign pipe_shift = pipe_in;
    end else begin : g_pipe_multi
      assign pipe_shift = {pipe_v[PIPE_LATENCY-2:0], pipe_in};
    end
  endgenerate

  assign pipe_next = pipe_en ? pipe_shift : pipe_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pipe_v  <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      lb_sel  <= 2'd0;
    end else begin
      pipe_v <= pipe_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            col_cnt <= '0;
            row_cnt <= '0;
            lb_sel  <= 2'd0;
            state   <= S_FILL;
          end
        end
        S_FILL, S_RUN: begin
          if (accept) begin
            if (last_col) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 16'd1;
              lb_sel  <= (lb_sel == 2'd2) ? 2'd0 : lb_sel + 2'd1;
              if (last_row) begin
                state <= S_FLUSH;
              end else if (row_cnt == 16'd1) begin
                state <= S_RUN;
              end
            end else begin
              col_cnt <= col_cnt + ADDR_WIDTH'(1);
            end
          end
        end
        S_FLUSH: begin
          // Leave as soon as the final result has been taken so frame_done
          // follows the last delivery by exactly one cycle.
          if (pipe_next == '0) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_median_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_median_stream_ctrl
// Purpose  : Self-checking bench for median_stream_ctrl. Two instances:
//            5x4 frame with latency 3, and a minimum 3x3 frame with latency 1.
//            A queue-based reference model tracks pending results by age.
// Revision : 1.0 - initial release
// ============================================================================
module tb_median_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a      [2];
  logic       in_valid_a   [2];
  logic       out_ready_a  [2];
  logic       in_ready_a   [2];
  logic       out_valid_a  [2];
  logic       pipe_en_a    [2];
  logic       lb_wr_en_a   [2];
  logic [9:0] lb_addr_a    [2];
  logic [1:0] lb_sel_a     [2];
  logic [9:0] col_cnt_a    [2];
  logic [15:0] row_cnt_a   [2];
  logic       busy_a       [2];
  logic       frame_done_a [2];

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      median_stream_ctrl #(
        .IMG_WIDTH   (g == 0 ? 5 : 3),
        .IMG_HEIGHT  (g == 0 ? 4 : 3),
        .ADDR_WIDTH  (10),
        .PIPE_LATENCY(g == 0 ? 3 : 1)
      ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start_a[g]),
        .in_valid  (in_valid_a[g]),
        .in_ready  (in_ready_a[g]),
        .out_ready (out_ready_a[g]),
        .out_valid (out_valid_a[g]),
        .pipe_en   (pipe_en_a[g]),
        .lb_wr_en  (lb_wr_en_a[g]),
        .lb_addr   (lb_addr_a[g]),
        .lb_sel    (lb_sel_a[g]),
        .col_cnt   (col_cnt_a[g]),
        .row_cnt   (row_cnt_a[g]),
        .busy      (busy_a[g]),
        .frame_done(frame_done_a[g])
      );
    end
  endgenerate

  int cfg = 0;
  int vectors = 0;
  int miscompares = 0;
  int timeout_cnt = 0;
  int timeout_seen = 0;

  // Reference model: phase 0 idle, 1 streaming, 2 flushing, 3 done.
  int m_phase, m_row, m_col, m_sel, m_delivered;
  int age_q[$];
  int mw, mh, ml;
  bit ov_e, stall_e, ir_e, pe_e, acc_e, was_flush;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cfg %0d, t=%0t)", name, act, exp, cfg, $time);
    end
  endtask

  // Scoreboard/monitor: samples mid-cycle on the falling edge, then advances
  // the model across the following rising edge.
  initial begin
    m_phase = 0; m_row = 0; m_col = 0; m_sel = 0; m_delivered = 0;
    forever begin
      @(negedge clk);
      mw = (cfg == 0) ? 5 : 3;
      mh = (cfg == 0) ? 4 : 3;
      ml = (cfg == 0) ? 3 : 1;
      if (timeout_cnt != timeout_seen) begin
        chk("frame_timeout", 64'(timeout_cnt), 64'(timeout_seen));
        timeout_seen = timeout_cnt;
      end
      if (rst) begin
        m_phase = 0; m_row = 0; m_col = 0; m_sel = 0; m_delivered = 0;
        age_q.delete();
        chk("reset_outputs",
            {out_valid_a[cfg], in_ready_a[cfg], pipe_en_a[cfg], lb_wr_en_a[cfg],
             busy_a[cfg], frame_done_a[cfg], lb_sel_a[cfg], lb_addr_a[cfg],
             col_cnt_a[cfg], row_cnt_a[cfg]}, 64'd0);
      end else begin
        ov_e    = (age_q.size() > 0) && (age_q[0] == ml);
        stall_e = ov_e && !out_ready_a[cfg];
        ir_e    = (m_phase == 1) && !stall_e;
        pe_e    = (m_phase == 1 || m_phase == 2) && !stall_e;
        acc_e   = in_valid_a[cfg] && ir_e;
        chk("out_valid",  out_valid_a[cfg],  ov_e);
        chk("in_ready",   in_ready_a[cfg],   ir_e);
        chk("pipe_en",    pipe_en_a[cfg],    pe_e);
        chk("busy",       busy_a[cfg],       m_phase != 0);
        chk("frame_done", frame_done_a[cfg], m_phase == 3);
        chk("lb_wr_en",   lb_wr_en_a[cfg],   acc_e);
        chk("col_cnt",    col_cnt_a[cfg],    64'(m_col));
        chk("row_cnt",    row_cnt_a[cfg],    64'(m_row));
        chk("lb_addr",    lb_addr_a[cfg],    64'(m_col));
        chk("lb_sel",     lb_sel_a[cfg],     64'(m_sel));

        if (out_valid_a[cfg] && out_ready_a[cfg]) begin
          if (age_q.size() == 0) begin
            chk("spurious_result", 64'd1, 64'd0);
          end else begin
            chk("result_age", 64'(age_q[0]), 64'(ml));
            void'(age_q.pop_front());
            m_delivered++;
          end
        end

        was_flush = (m_phase == 2);
        case (m_phase)
          0: begin
            if (start_a[cfg]) begin
              m_phase = 1; m_row = 0; m_col = 0; m_sel = 0;
            end
          end
          3: begin
            chk("result_count", 64'(m_delivered), 64'((mw - 2) * (mh - 2)));
            m_delivered = 0;
            m_phase = 0;
          end
          default: begin
            if (pe_e) begin
              foreach (age_q[i]) age_q[i]++;
            end
            if (acc_e) begin
              if (m_row >= 2 && m_col >= 2) age_q.push_back(1);
              if (m_col == mw - 1) begin
                m_col = 0;
                m_row++;
                m_sel = (m_sel + 1) % 3;
                if (m_row == mh) m_phase = 2;
              end else begin
                m_col++;
              end
            end
            if (was_flush && age_q.size() == 0) m_phase = 3;
          end
        endcase
      end
    end
  end

  // ivm: 0 continuous, 1 toggling, 2 random in_valid
  // orm: 0 always ready, 1 one 5-cycle stall on first result, 2 random
  task automatic run_frame(input int ivm, input int orm, input int abort_at, input bit start_mid);
    int  acc = 0;
    bit  done = 0;
    int  bp = 0;
    bit  bp_used = 0;
    int  w = (cfg == 0) ? 5 : 3;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      start_a[cfg] = (cyc == 0) || (start_mid && acc == 2 * w + 1);
      case (ivm)
        0:       in_valid_a[cfg] = 1'b1;
        1:       in_valid_a[cfg] = (cyc % 2 == 0);
        default: in_valid_a[cfg] = ($urandom_range(0, 3) != 0);
      endcase
      case (orm)
        0:       out_ready_a[cfg] = 1'b1;
        1:       out_ready_a[cfg] = (bp == 0);
        default: out_ready_a[cfg] = ($urandom_range(0, 2) != 0);
      endcase
      @(negedge clk);
      if (in_valid_a[cfg] && in_ready_a[cfg]) acc++;
      if (frame_done_a[cfg]) done = 1;
      if (orm == 1) begin
        if (bp > 0) bp--;
        else if (!bp_used && out_valid_a[cfg]) begin
          bp = 5;
          bp_used = 1;
        end
      end
      if (abort_at > 0 && acc >= abort_at) begin
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        start_a[cfg] = 1'b0;
        in_valid_a[cfg] = 1'b0;
        out_ready_a[cfg] = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
    start_a[cfg] = 1'b0;
    in_valid_a[cfg] = 1'b0;
    out_ready_a[cfg] = 1'b1;
    if (!done) timeout_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_a[i] = 1'b0;
      in_valid_a[i] = 1'b0;
      out_ready_a[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    run_frame(0, 0, 0, 0);   // continuous stream
    run_frame(0, 0, 12, 0);  // reset after 12 accepted pixels
    run_frame(0, 0, 0, 0);   // full frame after abandoned one
    run_frame(0, 1, 0, 0);   // downstream backpressure
    run_frame(1, 0, 0, 0);   // upstream bubbles
    for (int i = 0; i < 4; i++) run_frame(2, 2, 0, 0);

    // switch to the minimum-frame instance under reset
    #2 rst = 1'b1;
    cfg = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    run_frame(0, 0, 0, 1);   // start pulse while busy must be ignored
    for (int i = 0; i < 4; i++) run_frame(2, 2, 0, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
